// File: rtl/spy_host_pkg.sv
// spy_host_pkg: shared definitions for the spy bus host.
//   - bus state encodings (IDLE=0 .. RESP=4)
//   - default strobe timing constants and bus widths
//   - spy register addresses shared with the processor's spy decoder
//   - small helpers for sizing phase counters
package spy_host_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES   = 1;
    localparam int DEF_BOOT_CYCLES   = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // Spy register addresses, numbered to match the processor-side decoder.
    localparam logic [ADDR_W-1:0] SPY_IR_LO  = 4'h0;
    localparam logic [ADDR_W-1:0] SPY_IR_MID = 4'h1;
    localparam logic [ADDR_W-1:0] SPY_IR_HI  = 4'h2;
    localparam logic [ADDR_W-1:0] SPY_OPC    = 4'h3;
    localparam logic [ADDR_W-1:0] SPY_PC     = 4'h4;
    localparam logic [ADDR_W-1:0] SPY_OB_LO  = 4'h5;
    localparam logic [ADDR_W-1:0] SPY_OB_HI  = 4'h6;
    localparam logic [ADDR_W-1:0] SPY_FLAG1  = 4'h7;
    localparam logic [ADDR_W-1:0] SPY_FLAG2  = 4'h8;
    localparam logic [ADDR_W-1:0] SPY_MODE   = 4'hB;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold the value v (never less than 1).
    function automatic int cnt_width(input int v);
        int w;
        w = $clog2(v + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spy_host_boot_pulse_gen.sv
// boot_pulse_gen: produces the active-low boot pulse, BOOT_CYCLES wide.
// One pulse fires on the first clock after reset release; afterwards a
// pulse fires when boot_req is sampled high while no pulse is running.
// Requests during a pulse are dropped.
// Ports:
//   clk           in   system clock
//   power_reset_n in   asynchronous active-low reset
//   boot_req      in   level request for a pulse
//   boot_busy     out  pulse in progress
//   boot_n        out  boot switch, active low
module boot_pulse_gen
    import spy_host_pkg::*;
#(
    parameter int BOOT_CYCLES = DEF_BOOT_CYCLES
) (
    input  logic clk,
    input  logic power_reset_n,
    input  logic boot_req,
    output logic boot_busy,
    output logic boot_n
);

    localparam int BW = cnt_width(BOOT_CYCLES);

    logic          auto_q, auto_d;
    logic          busy_q, busy_d;
    logic          boot_n_q, boot_n_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          start;

    // auto_q is a one-shot that stands in for a request after reset.
    assign start = !busy_q && (auto_q || boot_req);

    always_comb begin
        auto_d   = auto_q;
        busy_d   = busy_q;
        boot_n_d = boot_n_q;
        cnt_d    = cnt_q;
        if (start) begin
            auto_d   = 1'b0;
            busy_d   = 1'b1;
            boot_n_d = 1'b0;
            cnt_d    = BW'(BOOT_CYCLES - 1);
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d   = 1'b0;
                boot_n_d = 1'b1;
            end else begin
                cnt_d = cnt_q - BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge power_reset_n) begin
        if (!power_reset_n) begin
            auto_q   <= 1'b1;
            busy_q   <= 1'b0;
            boot_n_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            auto_q   <= auto_d;
            busy_q   <= busy_d;
            boot_n_q <= boot_n_d;
            cnt_q    <= cnt_d;
        end
    end

    assign boot_busy = busy_q;
    assign boot_n    = boot_n_q;

endmodule

// File: rtl/spy_host.sv
// spy_host: host-side initiator for the spy/debug bus. Converts single-word
// valid/ready commands into registered eadr / dbread_n / dbwrite_n strobes
// on the shared 16-bit spy bus, returns read data, and owns the boot pulse.
// Ports:
//   clk, power_reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write, cmd_addr, cmd_wdata command contents
//   rsp_valid, rsp_rdata          completion pulse and last read data
//   boot_req, boot_busy           boot pulse request / status
//   spy                           bidirectional data bus
//   eadr, dbread_n, dbwrite_n     spy address and active-low strobes
//   boot1_n, boot2_n              boot switches, active low
module spy_host
    import spy_host_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int BOOT_CYCLES   = DEF_BOOT_CYCLES
) (
    input  logic              clk,
    input  logic              power_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              boot_req,
    output logic              boot_busy,
    inout  wire  [DATA_W-1:0] spy,
    output logic [ADDR_W-1:0] eadr,
    output logic              dbread_n,
    output logic              dbwrite_n,
    output logic              boot1_n,
    output logic              boot2_n
);

    localparam int CNT_W = cnt_width(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES));

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] eadr_q, eadr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oe_q, oe_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              boot_n;

    // Each phase counter is loaded with (length-1) on entry and the phase
    // ends on the cycle it reads zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        eadr_d      = eadr_q;
        wdata_d     = wdata_q;
        oe_d        = oe_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        ready_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready_q && cmd_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                    write_d = cmd_write;
                    eadr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    oe_d    = cmd_write;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = CNT_W'(STROBE_CYCLES - 1);
                    rd_n_d  = write_q;
                    wr_n_d  = !write_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    // Read data is taken on the edge that releases the strobe.
                    if (!write_q) begin
                        rdata_d = spy;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    oe_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge power_reset_n) begin
        if (!power_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            eadr_q      <= '0;
            oe_q        <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            eadr_q      <= eadr_d;
            oe_q        <= oe_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    // Write data is only visible while oe_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    assign spy       = oe_q ? wdata_q : {DATA_W{1'bz}};
    assign eadr      = eadr_q;
    assign dbread_n  = rd_n_q;
    assign dbwrite_n = wr_n_q;
    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

    boot_pulse_gen #(
        .BOOT_CYCLES (BOOT_CYCLES)
    ) u_boot (
        .clk           (clk),
        .power_reset_n (power_reset_n),
        .boot_req      (boot_req),
        .boot_busy     (boot_busy),
        .boot_n        (boot_n)
    );

    assign boot1_n = boot_n;
    assign boot2_n = boot_n;

endmodule

// File: tb/tb_spy_host.sv
module tb_spy_host;

    localparam int S    = 1;
    localparam int T    = 4;
    localparam int H    = 1;
    localparam int BOOT = 16;
    localparam int LAST = S + T + H + 2;
    localparam logic [15:0] PROBE = 16'h5A5A;

    logic        clk = 1'b0;
    logic        power_reset_n;
    logic        cmd_valid, cmd_write, boot_req;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_ready, rsp_valid, boot_busy;
    logic [15:0] rsp_rdata;
    logic [3:0]  eadr;
    logic        dbread_n, dbwrite_n, boot1_n, boot2_n;
    wire  [15:0] spy;
    logic        tb_oe;
    logic [15:0] tb_drv;

    assign spy = tb_oe ? tb_drv : 16'hzzzz;

    int total = 0;
    int bad   = 0;
    logic [15:0] model_rd;

    always #5 clk = ~clk;

    spy_host #(
        .SETUP_CYCLES (S),
        .STROBE_CYCLES(T),
        .HOLD_CYCLES  (H),
        .BOOT_CYCLES  (BOOT)
    ) dut (
        .clk          (clk),
        .power_reset_n(power_reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .boot_req     (boot_req),
        .boot_busy    (boot_busy),
        .spy          (spy),
        .eadr         (eadr),
        .dbread_n     (dbread_n),
        .dbwrite_n    (dbwrite_n),
        .boot1_n      (boot1_n),
        .boot2_n      (boot2_n)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] bus;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected per-cycle behaviour is derived from the phase lengths:
    // strobe low in cycles S+1..S+T, response in S+T+H+1, ready again after.
    task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [15:0] wd,
                           input logic [15:0] rd, input logic [15:0] exp_rdata, input string tag);
        int n = 0;
        bit strobe;
        while (!cmd_ready && n < 30) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, " ready-wait"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        tb_oe = !wr; tb_drv = ~rd;
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_wdata = $urandom;
            end
            if (wr) begin
                tb_oe = (k == S + T + H + 1); tb_drv = PROBE;
            end else begin
                tb_oe = 1'b1; tb_drv = (k == S + T) ? rd : ~rd;
            end
            #1;
            strobe = (k >= S + 1) && (k <= S + T);
            chk({tag, " eadr"}, 32'(eadr), 32'(a));
            chk({tag, " dbread_n"}, 32'(dbread_n), 32'(!(strobe && !wr)));
            chk({tag, " dbwrite_n"}, 32'(dbwrite_n), 32'(!(strobe && wr)));
            chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(k == S + T + H + 1));
            chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'(k == LAST));
            if (wr && k <= S + T + H) chk({tag, " spy wdata"}, 32'(spy), 32'(wd));
            if (wr && k == S + T + H + 1) chk({tag, " spy released"}, 32'(spy), 32'(PROBE));
            if (!wr) chk({tag, " spy undriven"}, 32'(spy), 32'(tb_drv));
            if (k >= S + T + H + 1) chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        end
        tb_oe = 1'b0;
    endtask

    // Starts at a point just after a negedge; the pulse must cover the
    // next BOOT sampled cycles and then end.
    task automatic check_boot_pulse(input string tag);
        for (int i = 1; i <= BOOT + 3; i++) begin
            @(negedge clk); #1;
            chk({tag, " boot1_n"}, 32'(boot1_n), 32'(i > BOOT));
            chk({tag, " boot2_n"}, 32'(boot2_n), 32'(i > BOOT));
            chk({tag, " boot_busy"}, 32'(boot_busy), 32'(i <= BOOT));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc1;
        tbl[0] = '{1'b0, 4'h4, 16'h0000, 16'hA5C3, 16'hA5C3};
        tbl[1] = '{1'b1, 4'hB, 16'h1234, 16'h0000, 16'hA5C3};
        tbl[2] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0000};
        tbl[3] = '{1'b0, 4'hF, 16'h0000, 16'hFFFF, 16'hFFFF};
        tbl[4] = '{1'b1, 4'h0, 16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[5] = '{1'b1, 4'hF, 16'h0000, 16'h0000, 16'hFFFF};

        power_reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 16'h0;
        boot_req = 1'b0; tb_oe = 1'b1; tb_drv = PROBE;
        repeat (3) @(negedge clk);
        #1;
        chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset eadr", 32'(eadr), 32'd0);
        chk("reset dbread_n", 32'(dbread_n), 32'd1);
        chk("reset dbwrite_n", 32'(dbwrite_n), 32'd1);
        chk("reset spy released", 32'(spy), 32'(PROBE));
        chk("reset boot1_n", 32'(boot1_n), 32'd1);
        chk("reset boot2_n", 32'(boot2_n), 32'd1);
        chk("reset boot_busy", 32'(boot_busy), 32'd0);
        @(negedge clk);
        power_reset_n = 1'b1; tb_oe = 1'b0;
        check_boot_pulse("autoboot");

        foreach (tbl[i])
            run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].bus, tbl[i].exp_rdata, $sformatf("vec%0d", i));
        model_rd = tbl[5].exp_rdata;

        // Back-to-back with cmd_valid held: accepts 8 cycles apart.
        @(negedge clk); #1;
        tb_oe = 1'b1; tb_drv = 16'hBEEF;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3;
        acc1 = -1;
        for (int t = 1; t <= 2 * LAST; t++) begin
            @(negedge clk); #1;
            if (t == 1) cmd_addr = 4'h9;
            if (cmd_ready && acc1 < 0) acc1 = t;
            if (t == 7) chk("b2b eadr first hold-end", 32'(eadr), 32'h3);
            if (t == 7) chk("b2b rsp_valid A", 32'(rsp_valid), 32'd1);
            if (t == 8) chk("b2b eadr at second accept", 32'(eadr), 32'h3);
            if (t == 9) begin
                chk("b2b eadr second", 32'(eadr), 32'h9);
                cmd_valid = 1'b0;
            end
            if (t == 15) chk("b2b rsp_valid B", 32'(rsp_valid), 32'd1);
        end
        chk("b2b accept spacing", 32'(acc1), 32'd8);
        chk("b2b rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
        tb_oe = 1'b0;
        model_rd = 16'hBEEF;

        for (int r = 0; r < 24; r++) begin
            logic wr;
            logic [3:0] a;
            logic [15:0] wd, rd;
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom);
            wd = 16'($urandom);
            rd = 16'($urandom);
            if (!wr) model_rd = rd;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
            run_cmd(wr, a, wd, rd, model_rd, $sformatf("rnd%0d", r));
        end

        // Boot request at idle, a second request mid-pulse, and a
        // concurrent bus read.
        @(negedge clk); #1;
        chk("bootreq idle busy", 32'(boot_busy), 32'd0);
        boot_req = 1'b1;
        fork
            check_boot_pulse("bootreq");
            begin
                @(negedge clk); boot_req = 1'b0;
                repeat (4) @(negedge clk);
                boot_req = 1'b1;
                @(negedge clk); boot_req = 1'b0;
                #1;
                run_cmd(1'b0, 4'h7, 16'h0, 16'h3C69, 16'h3C69, "concurrent");
            end
        join
        model_rd = 16'h3C69;

        // Reset in cycle 3 of a read.
        @(negedge clk); #1;
        tb_oe = 1'b1; tb_drv = 16'h7777;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            cmd_valid = 1'b0;
        end
        chk("midrst strobe low before", 32'(dbread_n), 32'd0);
        power_reset_n = 1'b0;
        #1;
        chk("midrst dbread_n", 32'(dbread_n), 32'd1);
        chk("midrst rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("midrst eadr", 32'(eadr), 32'd0);
        chk("midrst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst spy undriven", 32'(spy), 32'h7777);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        end
        tb_oe = 1'b0;
        @(negedge clk);
        power_reset_n = 1'b1;
        check_boot_pulse("rst-autoboot");
        run_cmd(1'b0, 4'h4, 16'h0, 16'hA5C3, 16'hA5C3, "post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
